// File: rtl/mc_control_fsm.sv
// Multi-cycle CPU control unit: sequences each instruction through fetch, decode,
// execute, memory and writeback, driving datapath load enables, strobes and mux selects.
module mc_control_fsm #(
  parameter int              OPW     = 4,
  parameter logic [OPW-1:0]  HALT_OP = 4'hF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] opcode,
  input  logic           zero,
  input  logic           mem_ready,
  output logic           pc_load,
  output logic           ir_load,
  output logic           a_load,
  output logic           b_load,
  output logic           alu_out_load,
  output logic           mdr_load,
  output logic           reg_write,
  output logic           mem_read,
  output logic           mem_write,
  output logic           iord,
  output logic           alu_src_a,
  output logic [1:0]     alu_src_b,
  output logic [1:0]     alu_op,
  output logic [1:0]     pc_src,
  output logic           reg_dst,
  output logic           mem_to_reg,
  output logic           halted,
  output logic [3:0]     state
);

  localparam logic [OPW-1:0] OP_ADDI = OPW'(4);
  localparam logic [OPW-1:0] OP_LW   = OPW'(5);
  localparam logic [OPW-1:0] OP_SW   = OPW'(6);
  localparam logic [OPW-1:0] OP_BEQ  = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP  = OPW'(8);

  localparam logic [1:0] SRC_B_REG   = 2'd0;
  localparam logic [1:0] SRC_B_ONE   = 2'd1;
  localparam logic [1:0] SRC_B_IMM   = 2'd2;
  localparam logic [1:0] ALU_ADD     = 2'd0;
  localparam logic [1:0] ALU_SUB     = 2'd1;
  localparam logic [1:0] ALU_FUNCT   = 2'd2;
  localparam logic [1:0] PC_ALU      = 2'd0;
  localparam logic [1:0] PC_ALUOUT   = 2'd1;
  localparam logic [1:0] PC_JUMP     = 2'd2;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_HALT      = 4'd10
  } state_t;

  state_t state_q;
  state_t state_d;

  logic is_rtype;
  assign is_rtype = (opcode < OP_ADDI);
  assign state    = state_q;

  // NOTE: sequential state uses non-blocking assignment so every register samples
  // pre-edge values; combinational blocks below use blocking assignment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every output and state_d gets a default before the case, so no path
  // leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d      = S_FETCH;
    pc_load      = 1'b0;
    ir_load      = 1'b0;
    a_load       = 1'b0;
    b_load       = 1'b0;
    alu_out_load = 1'b0;
    mdr_load     = 1'b0;
    reg_write    = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    iord         = 1'b0;
    alu_src_a    = 1'b0;
    alu_src_b    = SRC_B_REG;
    alu_op       = ALU_ADD;
    pc_src       = PC_ALU;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    halted       = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+1 is computed alongside the instruction read and committed with IR.
        mem_read  = 1'b1;
        alu_src_b = SRC_B_ONE;
        ir_load   = mem_ready;
        pc_load   = mem_ready;
        state_d   = mem_ready ? S_DECODE : S_FETCH;
      end

      S_DECODE: begin
        // Branch target is precomputed into ALUOut while the operands are read.
        a_load       = 1'b1;
        b_load       = 1'b1;
        alu_out_load = 1'b1;
        alu_src_b    = SRC_B_IMM;
        if (opcode == HALT_OP) begin
          state_d = S_HALT;
        end else if (is_rtype) begin
          state_d = S_EXECUTE;
        end else if (opcode == OP_ADDI || opcode == OP_LW || opcode == OP_SW) begin
          state_d = S_MEM_ADDR;
        end else if (opcode == OP_BEQ) begin
          state_d = S_BRANCH;
        end else if (opcode == OP_JMP) begin
          state_d = S_JUMP;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRC_B_IMM;
        alu_out_load = 1'b1;
        if (opcode == OP_LW) begin
          state_d = S_MEM_READ;
        end else if (opcode == OP_SW) begin
          state_d = S_MEM_WRITE;
        end else if (opcode == OP_ADDI) begin
          state_d = S_ALU_WB;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        mdr_load = mem_ready;
        state_d  = mem_ready ? S_MEM_WB : S_MEM_READ;
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        state_d   = mem_ready ? S_FETCH : S_MEM_WRITE;
      end

      S_EXECUTE: begin
        alu_src_a    = 1'b1;
        alu_op       = ALU_FUNCT;
        alu_out_load = 1'b1;
        state_d      = S_ALU_WB;
      end

      S_ALU_WB: begin
        // R-type writes rd=IR[7:4]; ADDI writes IR[11:8].
        reg_write = 1'b1;
        reg_dst   = is_rtype;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_SUB;
        pc_src    = PC_ALUOUT;
        pc_load   = zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_src  = PC_JUMP;
        pc_load = 1'b1;
        state_d = S_FETCH;
      end

      S_HALT: begin
        halted  = 1'b1;
        state_d = S_HALT;
      end

      default: state_d = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Self-checking bench for mc_control_fsm: directed scenarios plus random instruction
// streams compared cycle by cycle against a trace model of each instruction.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_load, ir_load, a_load, b_load, alu_out_load, mdr_load;
  logic       reg_write, mem_read, mem_write, iord, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_src;
  logic       reg_dst, mem_to_reg, halted;
  logic [3:0] state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_control_fsm dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_load(pc_load), .ir_load(ir_load), .a_load(a_load), .b_load(b_load),
    .alu_out_load(alu_out_load), .mdr_load(mdr_load), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .halted(halted), .state(state)
  );

  typedef struct packed {
    logic       pc_load, ir_load, a_load, b_load, alu_out_load, mdr_load;
    logic       reg_write, mem_read, mem_write, iord, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic       reg_dst, mem_to_reg, halted;
    logic [3:0] state;
  } obs_t;

  // One cycle of an instruction trace: the state expected and the mem_ready to drive
  // (-1 means any value, chosen at random).
  typedef struct {
    logic [3:0] st;
    int         rdy;
  } step_t;

  localparam logic [3:0] FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_READ = 4'd3,
                         MEM_WB = 4'd4, MEM_WRITE = 4'd5, EXECUTE = 4'd6, ALU_WB = 4'd7,
                         BRANCH = 4'd8, JUMP = 4'd9, HALT = 4'd10;

  obs_t dut_obs;
  assign dut_obs = {pc_load, ir_load, a_load, b_load, alu_out_load, mdr_load, reg_write,
                    mem_read, mem_write, iord, alu_src_a, alu_src_b, alu_op, pc_src,
                    reg_dst, mem_to_reg, halted, state};

  // Control word each state must present, straight from the per-state rules.
  function automatic obs_t expect_out(input logic [3:0] st, input logic [3:0] opc,
                                      input logic z, input logic rdy);
    obs_t e = '0;
    e.state = st;
    case (st)
      FETCH:     begin e.mem_read = 1; e.alu_src_b = 2'd1; e.ir_load = rdy; e.pc_load = rdy; end
      DECODE:    begin e.a_load = 1; e.b_load = 1; e.alu_out_load = 1; e.alu_src_b = 2'd2; end
      MEM_ADDR:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_out_load = 1; end
      MEM_READ:  begin e.mem_read = 1; e.iord = 1; e.mdr_load = rdy; end
      MEM_WB:    begin e.reg_write = 1; e.mem_to_reg = 1; end
      MEM_WRITE: begin e.mem_write = 1; e.iord = 1; end
      EXECUTE:   begin e.alu_src_a = 1; e.alu_op = 2'd2; e.alu_out_load = 1; end
      ALU_WB:    begin e.reg_write = 1; e.reg_dst = (opc <= 4'd3); end
      BRANCH:    begin e.alu_src_a = 1; e.alu_op = 2'd1; e.pc_src = 2'd1; e.pc_load = z; end
      JUMP:      begin e.pc_src = 2'd2; e.pc_load = 1; end
      HALT:      e.halted = 1;
      default:   e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input obs_t obs, input obs_t exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (state obs %0d exp %0d)",
             tag, obs, exp, obs.state, exp.state);
    end
  endtask

  // Called at posedge+1: drive inputs, sample the Moore/combinational outputs, advance.
  task automatic step(input logic [3:0] st, input logic [3:0] opc, input logic rdy,
                      input logic z, input string tag);
    opcode    = opc;
    mem_ready = rdy;
    zero      = z;
    #1;
    check(tag, dut_obs, expect_out(st, opc, z, rdy));
    @(posedge clk);
    #1;
  endtask

  // Expand one instruction into its cycle trace from its class and the wait counts.
  task automatic run_instr(input logic [3:0] opc, input int fw, input int mw,
                           input int zsel, input int halt_cycles, input string tag);
    step_t q[$];
    logic  z, r;
    for (int i = 0; i < fw; i++) q.push_back('{FETCH, 0});
    q.push_back('{FETCH, 1});
    q.push_back('{DECODE, -1});
    if (opc <= 4'd3) begin
      q.push_back('{EXECUTE, -1}); q.push_back('{ALU_WB, -1});
    end else if (opc == 4'd4) begin
      q.push_back('{MEM_ADDR, -1}); q.push_back('{ALU_WB, -1});
    end else if (opc == 4'd5) begin
      q.push_back('{MEM_ADDR, -1});
      for (int i = 0; i < mw; i++) q.push_back('{MEM_READ, 0});
      q.push_back('{MEM_READ, 1}); q.push_back('{MEM_WB, -1});
    end else if (opc == 4'd6) begin
      q.push_back('{MEM_ADDR, -1});
      for (int i = 0; i < mw; i++) q.push_back('{MEM_WRITE, 0});
      q.push_back('{MEM_WRITE, 1});
    end else if (opc == 4'd7) begin
      q.push_back('{BRANCH, -1});
    end else if (opc == 4'd8) begin
      q.push_back('{JUMP, -1});
    end else if (opc == 4'hF) begin
      for (int i = 0; i < halt_cycles; i++) q.push_back('{HALT, -1});
    end
    foreach (q[i]) begin
      r = (q[i].rdy < 0) ? 1'($urandom_range(0, 1)) : 1'(q[i].rdy);
      z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
      step(q[i].st, (q[i].st == FETCH) ? 4'($urandom_range(0, 15)) : opc, r, z,
           $sformatf("%s op%0h cyc%0d", tag, opc, i));
    end
  endtask

  initial begin
    rst_n = 1'b0; opcode = 4'h0; zero = 1'b0; mem_ready = 1'b0;
    #2;
    check("reset_state", dut_obs, expect_out(FETCH, 4'h0, 1'b0, 1'b0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed: ADD, LW with two read waits, BEQ taken / not taken, JMP, illegal 0xA.
    run_instr(4'h0, 0, 0, -1, 0, "add");
    run_instr(4'h5, 0, 2, -1, 0, "lw_wait2");
    run_instr(4'h7, 0, 0, 1, 0, "beq_taken");
    run_instr(4'h7, 0, 0, 0, 0, "beq_not");
    run_instr(4'h8, 0, 0, -1, 0, "jmp");
    run_instr(4'hA, 0, 0, -1, 0, "illegal");
    run_instr(4'h6, 1, 3, -1, 0, "sw_waits");
    run_instr(4'h4, 2, 0, -1, 0, "addi");

    // Asynchronous reset while in EXECUTE: no edge needed for FETCH to appear.
    step(FETCH, 4'h1, 1'b1, 1'b0, "rst_fetch");
    step(DECODE, 4'h1, 1'b0, 1'b0, "rst_decode");
    opcode = 4'h1; mem_ready = 1'b0;
    #1;
    check("rst_pre_execute", dut_obs, expect_out(EXECUTE, 4'h1, 1'b0, 1'b0));
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_async_fetch", dut_obs, expect_out(FETCH, 4'h1, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    check("rst_held", dut_obs, expect_out(FETCH, 4'h1, 1'b0, 1'b0));
    rst_n = 1'b1;
    run_instr(4'h1, 0, 0, -1, 0, "post_rst_sub");

    // Random instruction stream (HALT excluded so the stream keeps running).
    for (int n = 0; n < 80; n++) begin
      run_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1, 0, "rand");
    end

    // HALT holds for many cycles until reset.
    run_instr(4'hF, 1, 0, -1, 25, "halt");
    rst_n = 1'b0;
    #1;
    check("halt_reset", dut_obs, expect_out(FETCH, 4'h0, zero, mem_ready));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_instr(4'h0, 0, 0, -1, 0, "after_halt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle CPU control unit. It sequences each instruction through fetch, decode, execute, memory and writeback states. It drives the load enables of the 16-bit datapath registers (PC, IR, A, B, ALUOut, MDR), the register-file write, memory strobes and the datapath mux selects. It sits directly upstream of every datapath register: its *_load outputs feed those registers' load inputs, sampled on the same clk edge.

Parameters:
OPW, 4, opcode width (instruction bits [15:12])
HALT_OP, 4'hF, opcode that enters HALT

Ports:
clk  input  1  system clock, all state changes on posedge
rst_n  input  1  asynchronous active-low reset
opcode  input  OPW  IR[15:12], valid from DECODE onward
zero  input  1  ALU zero flag, combinational from datapath
mem_ready  input  1  memory handshake: read data valid / write accepted this cycle
pc_load  output  1  PC register load enable
ir_load  output  1  IR load enable
a_load  output  1  A register load enable
b_load  output  1  B register load enable
alu_out_load  output  1  ALUOut register load enable
mdr_load  output  1  MDR load enable
reg_write  output  1  register-file write enable
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
iord  output  1  address mux: 0=PC, 1=ALUOut
alu_src_a  output  1  0=PC, 1=A
alu_src_b  output  2  0=B, 1=const 1, 2=sign-ext imm[7:0]
alu_op  output  2  0=add, 1=sub, 2=funct per opcode
pc_src  output  2  0=ALU result, 1=ALUOut, 2=jump target IR[11:0]
reg_dst  output  1  0=IR[11:8], 1=IR[7:4]
mem_to_reg  output  1  0=ALUOut, 1=MDR
halted  output  1  high while in HALT
state  output  4  current state encoding, debug

Behaviour:
- Opcodes: 0-3 ALU R-type (ADD, SUB, AND, OR); 4 ADDI; 5 LW; 6 SW; 7 BEQ; 8 JMP; HALT_OP HALT. Any other opcode is illegal and executes as a NOP: DECODE -> FETCH.
- State encoding: FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, ALU_WB=7, BRANCH=8, JUMP=9, HALT=10. Codes 11-15 go to FETCH on the next edge.
- Reset: asynchronous on rst_n low, state=FETCH. All outputs are Moore decodes of state, so during reset they show FETCH values: mem_read=1, iord=0, all loads/writes 0. Reset mid-instruction abandons the instruction with no partial writeback.
- All outputs are combinational from state (and zero, mem_ready where noted). Unlisted outputs are 0 in each state.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0. ir_load=pc_load=mem_ready. The FSM stays in FETCH while mem_ready=0 and goes to DECODE when mem_ready=1.
- DECODE: a_load=b_load=1. alu_out_load=1 with alu_src_a=0, alu_src_b=2, alu_op=0, which precomputes the branch target. Next state: 0-3 -> EXECUTE; 4,5,6 -> MEM_ADDR; 7 -> BRANCH; 8 -> JUMP; HALT_OP -> HALT; else -> FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, alu_op=0, alu_out_load=1. Next state: LW -> MEM_READ; SW -> MEM_WRITE; ADDI -> ALU_WB.
- MEM_READ: mem_read=1, iord=1, mdr_load=mem_ready. Stays while mem_ready=0; goes to MEM_WB on mem_ready=1.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Next state FETCH.
- MEM_WRITE: mem_write=1, iord=1. Stays while mem_ready=0; goes to FETCH on mem_ready=1.
- EXECUTE: alu_src_a=1, alu_src_b=0, alu_op=2, alu_out_load=1. Next state ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. reg_dst=1 for R-type, 0 for ADDI. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_src=1, pc_load=zero. Next state FETCH.
- JUMP: pc_src=2, pc_load=1. Next state FETCH.
- HALT: halted=1, all loads/strobes 0. The FSM stays in HALT until reset.
- Latency without memory waits: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/JMP 3, illegal 2.
- Each memory wait cycle adds exactly one cycle. Strobes stay asserted continuously through waits.
- The FSM never asserts mem_read and mem_write together, and never asserts pc_load and reg_write together.

Test Plan:
- Reset: hold rst_n=0 mid-EXECUTE, asynchronously -> state=0 immediately, mem_read=1, all loads 0, reg_write=0; release with mem_ready=1 -> DECODE next edge.
- ADD (opcode 0), mem_ready=1 -> states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in cycle 4. ir_load and pc_load pulse only in cycle 1.
- LW with mem_ready low for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. mdr_load=1 only on the third MEM_READ cycle; mem_read held high throughout.
- BEQ with zero=1 then zero=0 -> pc_load=1, pc_src=1 in BRANCH for the first; pc_load=0 for the second; both return to FETCH after 3 cycles.
- JMP (8) -> pc_load=1, pc_src=2 in cycle 3. Opcode 4'hA -> DECODE -> FETCH, no writes.
- HALT (4'hF) -> halted=1 from cycle 3 for 20+ cycles with no strobes; assert rst_n=0 -> halted=0, state=FETCH.
